// File: rtl/conv_param_loader.sv
// Streams LeNet-5 conv weights (bytes) and biases (little-endian 32-bit words) from a byte
// interface into the weight and bias RAM write ports, with an inter-byte idle timeout.
module conv_param_loader #(
   parameter int N_WEIGHTS   = 2550,
   parameter int N_BIASES    = 22,
   parameter int W_ADDR_W    = 12,
   parameter int B_ADDR_W    = 5,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                in_valid,
   input  logic [7:0]          in_data,
   output logic                in_ready,
   output logic                w_wr_en,
   output logic [W_ADDR_W-1:0] w_wr_addr,
   output logic [7:0]          w_wr_data,
   output logic                b_wr_en,
   output logic [B_ADDR_W-1:0] b_wr_addr,
   output logic [31:0]         b_wr_data,
   output logic                busy,
   output logic                loaded,
   output logic                error
);

   localparam int IDLE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

   if (W_ADDR_W < $clog2(N_WEIGHTS)) begin : g_waddr_chk
      $error("W_ADDR_W too narrow for N_WEIGHTS");
   end
   if (B_ADDR_W < $clog2(N_BIASES)) begin : g_baddr_chk
      $error("B_ADDR_W too narrow for N_BIASES");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_WEIGHTS,
      S_BIASES,
      S_FINISH,
      S_DONE,
      S_ERROR
   } state_t;

   state_t              state, state_next;
   logic [W_ADDR_W-1:0] wcnt;
   logic [B_ADDR_W-1:0] bcnt;
   logic [1:0]          byte_idx;
   logic [23:0]         asm_q;
   logic [IDLE_W-1:0]   idle_cnt;
   logic                transfer;
   logic                last_weight;
   logic                last_bias_word;
   logic                timeout_hit;

   assign transfer       = in_valid & in_ready;
   assign last_weight    = (wcnt == W_ADDR_W'(N_WEIGHTS - 1));
   assign last_bias_word = (bcnt == B_ADDR_W'(N_BIASES - 1));
   // Fires on the TIMEOUT_CYC-th consecutive cycle without a transfer.
   assign timeout_hit    = (TIMEOUT_CYC != 0) && !transfer &&
                           (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (start) state_next = S_WEIGHTS;
         S_WEIGHTS: begin
            if (transfer && last_weight) state_next = S_BIASES;
            else if (timeout_hit)        state_next = S_ERROR;
         end
         S_BIASES: begin
            if (transfer && (byte_idx == 2'd3) && last_bias_word) state_next = S_FINISH;
            else if (timeout_hit)                                 state_next = S_ERROR;
         end
         S_FINISH:  state_next = S_DONE;
         S_DONE:    if (start) state_next = S_WEIGHTS;
         S_ERROR:   if (start) state_next = S_WEIGHTS;
         default:   state_next = S_IDLE;
      endcase
   end

   // Status flags are registered from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         loaded    <= 1'b0;
         error     <= 1'b0;
         w_wr_en   <= 1'b0;
         w_wr_addr <= '0;
         w_wr_data <= '0;
         b_wr_en   <= 1'b0;
         b_wr_addr <= '0;
         b_wr_data <= '0;
         wcnt      <= '0;
         bcnt      <= '0;
         byte_idx  <= '0;
         asm_q     <= '0;
         idle_cnt  <= '0;
      end else begin
         state    <= state_next;
         in_ready <= (state_next == S_WEIGHTS) || (state_next == S_BIASES);
         busy     <= (state_next == S_WEIGHTS) || (state_next == S_BIASES) ||
                     (state_next == S_FINISH);
         loaded   <= (state_next == S_DONE);
         error    <= (state_next == S_ERROR);
         w_wr_en  <= 1'b0;
         b_wr_en  <= 1'b0;

         if ((state_next == S_WEIGHTS) && (state != S_WEIGHTS)) begin
            wcnt     <= '0;
            bcnt     <= '0;
            byte_idx <= '0;
            asm_q    <= '0;
            idle_cnt <= '0;
         end else begin
            if ((state == S_WEIGHTS) || (state == S_BIASES))
               idle_cnt <= transfer ? '0 : idle_cnt + 1'b1;

            if (transfer && (state == S_WEIGHTS)) begin
               w_wr_en   <= 1'b1;
               w_wr_addr <= wcnt;
               w_wr_data <= in_data;
               wcnt      <= wcnt + 1'b1;
            end

            // The fourth byte goes straight into the write word; earlier bytes fill the assembler.
            if (transfer && (state == S_BIASES)) begin
               if (byte_idx == 2'd3) begin
                  b_wr_en   <= 1'b1;
                  b_wr_addr <= bcnt;
                  b_wr_data <= {in_data, asm_q};
                  bcnt      <= bcnt + 1'b1;
                  byte_idx  <= '0;
                  asm_q     <= '0;
               end else begin
                  asm_q[{byte_idx, 3'b000} +: 8] <= in_data;
                  byte_idx                       <= byte_idx + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_conv_param_loader.sv
// Testbench for conv_param_loader: table of full loads plus hand-written timeout, reset and
// boundary sequences, checked against a byte-stream reference model.
module tb_conv_param_loader;

   localparam int N_W     = 2550;
   localparam int N_B     = 22;
   localparam int W_AW    = 12;
   localparam int B_AW    = 5;
   // Larger than the longest random gap (20) so gapped loads never time out.
   localparam int TO      = 24;
   localparam int N_BYTES = N_W + 4 * N_B;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic            in_valid;
   logic [7:0]      in_data;
   logic            in_ready;
   logic            w_wr_en;
   logic [W_AW-1:0] w_wr_addr;
   logic [7:0]      w_wr_data;
   logic            b_wr_en;
   logic [B_AW-1:0] b_wr_addr;
   logic [31:0]     b_wr_data;
   logic            busy;
   logic            loaded;
   logic            error;

   always #5 clk = ~clk;

   conv_param_loader #(
      .N_WEIGHTS  (N_W),
      .N_BIASES   (N_B),
      .W_ADDR_W   (W_AW),
      .B_ADDR_W   (B_AW),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .w_wr_en  (w_wr_en),
      .w_wr_addr(w_wr_addr),
      .w_wr_data(w_wr_data),
      .b_wr_en  (b_wr_en),
      .b_wr_addr(b_wr_addr),
      .b_wr_data(b_wr_data),
      .busy     (busy),
      .loaded   (loaded),
      .error    (error)
   );

   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      string name;
      bit    gaps;
      bit    rnd;
      int    start_at;
      int    exp_w;
      int    exp_b;
      bit    exp_loaded;
      bit    exp_error;
   } vec_t;

   int         n_cmp  = 0;
   int         n_fail = 0;
   wr_t        wq[$];
   wr_t        bq[$];
   bit         overlap = 1'b0;
   logic [7:0] stream[$];
   vec_t       vecs[4];

   // Write-port monitor: logs every strobe so the reference model can compare whole sequences.
   always @(negedge clk) begin
      if (w_wr_en) wq.push_back('{int'(w_wr_addr), 32'(w_wr_data)});
      if (b_wr_en) bq.push_back('{int'(b_wr_addr), b_wr_data});
      if (w_wr_en && b_wr_en) overlap = 1'b1;
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input longint actual, input longint expected);
      n_cmp++;
      if (actual != expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic longint all_outputs();
      return longint'({in_ready, w_wr_en, w_wr_addr, w_wr_data, b_wr_en, b_wr_addr,
                       b_wr_data, busy, loaded, error});
   endfunction

   function automatic void build_stream(input bit rnd);
      logic [31:0] word;
      stream.delete();
      for (int i = 0; i < N_W; i++)
         stream.push_back(rnd ? 8'($urandom) : 8'(i % 256));
      for (int k = 0; k < N_B; k++) begin
         word = rnd ? $urandom : 32'hA500_0000 + 32'(k);
         for (int j = 0; j < 4; j++) stream.push_back(word[8*j +: 8]);
      end
   endfunction

   // Reference model: byte i < N_W lands at weight address i; bias k is bytes 4k..4k+3 after
   // the weights, little-endian.
   task automatic verify_load(input string tag, input int exp_w, input int exp_b);
      int bad;
      int base;
      check_output({tag, " w_count"}, wq.size(), exp_w);
      bad = -1;
      for (int i = 0; i < wq.size() && i < exp_w; i++)
         if (wq[i].addr != i || wq[i].data != 32'(stream[i])) begin
            bad = i;
            break;
         end
      check_output({tag, " w_first_bad"}, bad, -1);
      check_output({tag, " b_count"}, bq.size(), exp_b);
      bad = -1;
      for (int k = 0; k < bq.size() && k < exp_b; k++) begin
         base = N_W + 4 * k;
         if (bq[k].addr != k ||
             bq[k].data != {stream[base+3], stream[base+2], stream[base+1], stream[base]}) begin
            bad = k;
            break;
         end
      end
      check_output({tag, " b_first_bad"}, bad, -1);
      check_output({tag, " strobe_overlap"}, longint'(overlap), 0);
   endtask

   // Sends stream[0..n_bytes-1]; called and returns on a falling edge.
   task automatic apply_stimulus(input bit gaps, input int n_bytes, input int start_at,
                                 output bit ok);
      int w;
      ok = 1'b1;
      for (int i = 0; i < n_bytes; i++) begin
         if (gaps && $urandom_range(3, 0) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(20, 1)) @(negedge clk);
         end
         in_valid = 1'b1;
         in_data  = stream[i];
         start    = (i == start_at);
         w = 0;
         while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
         end
         if (!in_ready) begin
            check_output("accept_wait", 0, 1);
            in_valid = 1'b0;
            start    = 1'b0;
            ok       = 1'b0;
            return;
         end
         @(negedge clk);
         start = 1'b0;
         if (i == N_W - 1)
            check_output("last_weight_write", longint'({w_wr_en, w_wr_addr, w_wr_data}),
                         longint'({1'b1, 12'd2549, stream[i]}));
         if (i == N_W)
            check_output("first_bias_byte_no_write", longint'({w_wr_en, b_wr_en, in_ready}),
                         longint'(3'b001));
      end
      in_valid = 1'b0;
   endtask

   task automatic begin_load(input string tag, input bit rnd);
      build_stream(rnd);
      wq.delete();
      bq.delete();
      overlap = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_output({tag, " start_accept"}, longint'({loaded, error, busy, in_ready}),
                   longint'(4'b0011));
   endtask

   task automatic run_load(input vec_t v);
      bit ok;
      begin_load(v.name, v.rnd);
      apply_stimulus(v.gaps, N_BYTES, v.start_at, ok);
      if (ok) begin
         check_output({v.name, " finish_cycle"}, longint'({b_wr_en, loaded, in_ready}),
                      longint'(3'b100));
         @(negedge clk);
         check_output({v.name, " done_cycle"}, longint'({loaded, error, busy, b_wr_en}),
                      longint'({v.exp_loaded, v.exp_error, 2'b00}));
      end
      verify_load(v.name, v.exp_w, v.exp_b);
   endtask

   initial begin
      bit   ok;
      vec_t rv;

      vecs[0] = '{"pattern_b2b",  1'b0, 1'b0, -1,  N_W, N_B, 1'b1, 1'b0};
      vecs[1] = '{"pattern_gaps", 1'b1, 1'b0, -1,  N_W, N_B, 1'b1, 1'b0};
      vecs[2] = '{"random_gaps",  1'b1, 1'b1, -1,  N_W, N_B, 1'b1, 1'b0};
      vecs[3] = '{"start_mid",    1'b0, 1'b1, 700, N_W, N_B, 1'b1, 1'b0};

      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_output("reset_outputs", all_outputs(), 0);
      rst_n = 1'b1;
      @(negedge clk);

      in_valid = 1'b1;
      in_data  = 8'h5A;
      repeat (5) @(negedge clk);
      in_valid = 1'b0;
      check_output("idle_ignores_valid", longint'({in_ready, busy}) + wq.size(), 0);

      for (int i = 0; i < 4; i++) run_load(vecs[i]);

      // Stall after three bytes of bias word 5.
      begin_load("timeout", 1'b0);
      apply_stimulus(1'b0, N_W + 4 * 5 + 3, -1, ok);
      repeat (TO - 1) @(negedge clk);
      check_output("timeout_not_early", longint'(error), 0);
      @(negedge clk);
      check_output("timeout_error", longint'({error, in_ready, busy, loaded}),
                   longint'(4'b1000));
      repeat (4) @(negedge clk);
      check_output("timeout_no_partial_bias", bq.size() + wq.size(), N_W + 5);
      rv = '{"reload_after_error", 1'b0, 1'b1, -1, N_W, N_B, 1'b1, 1'b0};
      run_load(rv);

      // Asynchronous reset after 1000 weight bytes.
      begin_load("reset_mid", 1'b0);
      apply_stimulus(1'b0, 1000, -1, ok);
      #3 rst_n = 1'b0;
      #1 check_output("reset_mid_outputs", all_outputs(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rv = '{"reload_after_reset", 1'b1, 1'b0, -1, N_W, N_B, 1'b1, 1'b0};
      run_load(rv);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
